fpu_addsub_param: RTL and testbench
===================================

# fpu_addsub_param

- Parametrised, multi-cycle floating-point adder/subtractor; next generation of the team's 32-bit FPU.
- Adds configurable exponent and mantissa widths, an add/subtract mode and a start/done handshake.
- Adds guard/round/sticky rounding and a registered 4-bit status word.
- Sits between the operand registers and the result bus; default format is 1 sign + 6 exponent (bias 31) + 25 mantissa = 32 bits.

## Interface
- EXP_W, 6, exponent width (≥3); bias = 2^(EXP_W-1)-1.
- MANT_W, 25, stored mantissa width (≥4); hidden leading 1.
- W = 1+EXP_W+MANT_W is derived and not overridable.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start_in  in  1  accept operands; sampled only when busy_out=0.
- op_in  in  1  0 = A+B, 1 = A−B; latched with operands.
- op_A_in  in  W  operand A {sign, exp, mant}.
- op_B_in  in  W  operand B.
- busy_out  out  1  high in ALIGN, ADD, NORM, ROUND.
- done_out  out  1  one-cycle pulse; data_out/status_out valid.
- data_out  out  W  result; held until the next DONE.
- status_out  out  4  [3] zero, [2] overflow, [1] underflow, [0] inexact.

## Operation
- Reset value of every output: busy_out=0, done_out=0, data_out=0, status_out=0; FSM returns to IDLE.
- States: IDLE → ALIGN → ADD → NORM (1..MANT_W+2 cycles) → ROUND → DONE → IDLE, or DONE → ALIGN when start_in=1 in DONE.
- IDLE/DONE: start_in=1 latches A, B and op_in. start_in in any other state is ignored.
- Operand classes:
  - exp=0 is zero, whatever the mantissa.
  - exp=all-ones on either input forces the overflow result.
  - No denormals.
- ALIGN:
  - op_in=1 inverts B's sign.
  - Swap operands so the larger magnitude is first.
  - Right-shift the smaller operand by the exponent difference in one barrel shift, keeping guard, round and sticky bits.
  - A difference > MANT_W+2 leaves only sticky.
- ADD: magnitude add or subtract by sign. A carry-out right-shifts by 1 (lost bit goes into sticky) and increments the exponent.
- NORM:
  - A zero mantissa exits at once with result +0 and zero=1.
  - Otherwise left-shift 1 bit per cycle and decrement the exponent until the hidden bit is 1.
  - If the exponent would reach 0: flush to signed zero with underflow=1, zero=1, inexact=1.
- ROUND: rounding per Configuration. A rounding carry increments the exponent.
- Overflow (final exp ≥ all-ones): data_out={sign, all-ones, 0}, overflow=1, inexact=1.
- inexact=1 whenever any discarded guard/round/sticky bit was 1.
- Exact cancellation always gives +0.

## Timing
- Edge e0 samples start_in. done_out is high in the cycle after edge e0+4+n, where n = NORM left-shift count (0..MANT_W+1).
- The latency is therefore 4+n cycles.
- data_out and status_out update on the same edge that raises done_out.
- Back-to-back: start_in=1 during DONE gives the next DONE no earlier than 4 cycles later. busy_out is never high in DONE.
- reset=1 in any state:
  - next edge returns to IDLE and clears all outputs;
  - the in-flight operation never reports done;
  - reset wins over a simultaneous start_in.

## Configuration
- FPU_ROUND_NEAREST_EN defined: round-to-nearest, ties-to-even, using guard/round/sticky.
- FPU_ROUND_NEAREST_EN undefined: truncate (round toward zero). The ROUND state still takes 1 cycle and inexact is still reported.

## Test plan
- A={0,011111,0} (1.0), B={0,100000,0} (2.0), op=0 → data_out={0,100000,1,24'b0} (3.0), status 0000, done 4 cycles after start.
- A=B=1.0, op=1 → data_out=0, status 1000, latency 4.
- A={0,011111,25'b1}, B=1.0, op=1 → data_out={0,000110,0}, status 0000, n=25, latency 29.
- A=B={0,111110,all-ones}, op=0 → data_out={0,111111,0}, status 0101.
- A=1.0, B={0,000101,1,24'b0}, op=0:
  - with FPU_ROUND_NEAREST_EN → {0,011111,25'b1}, status 0001;
  - without it → {0,011111,0}, status 0001.
- Start an operation, assert reset for 1 cycle in NORM → all outputs 0 next cycle, no done pulse; a fresh 1.0+2.0 then completes normally.

Source files
------------

// File: rtl/fpu_addsub_param.sv
// Multi-cycle parametrised floating-point adder/subtractor with a start/done handshake.
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub_param #(
    parameter int unsigned EXP_W  = 6,
    parameter int unsigned MANT_W = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_in,
    input  logic                  op_in,
    input  logic [EXP_W+MANT_W:0] op_A_in,
    input  logic [EXP_W+MANT_W:0] op_B_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [EXP_W+MANT_W:0] data_out,
    output logic [3:0]            status_out
);
    localparam int unsigned W    = 1 + EXP_W + MANT_W;
    localparam int unsigned SigW = MANT_W + 1;
    localparam int unsigned ExtW = SigW + 3;

    localparam logic [EXP_W-1:0] ExpOnes = '1;
    localparam logic [EXP_W:0]   ExpInc  = {{EXP_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            op_q, op_d;
    logic            sign_q, sign_d;
    logic [EXP_W:0]  exp_q, exp_d;
    logic [ExtW-1:0] big_q, big_d;
    logic [ExtW-1:0] small_q, small_d;
    logic [ExtW-1:0] man_q, man_d;
    logic            sub_q, sub_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            uf_q, uf_d;
    logic [W-1:0]    data_q, data_d;
    logic [3:0]      status_q, status_d;

    // Operand unpack, magnitude ordering and alignment shifter.
    logic              sa, sb, s_big;
    logic [EXP_W-1:0]  ea, eb, e_big, e_small;
    logic [MANT_W-1:0] ma, mb;
    logic [SigW-1:0]   siga, sigb, sig_big, sig_small;
    logic              a_ge_b;
    logic [31:0]       shamt;
    logic [2*ExtW-1:0] wide;
    logic [ExtW-1:0]   aligned;

    always_comb begin
        sa   = a_q[W-1];
        ea   = a_q[W-2 -: EXP_W];
        ma   = a_q[MANT_W-1:0];
        sb   = b_q[W-1] ^ op_q;
        eb   = b_q[W-2 -: EXP_W];
        mb   = b_q[MANT_W-1:0];
        siga = (ea == '0) ? '0 : {1'b1, ma};
        sigb = (eb == '0) ? '0 : {1'b1, mb};

        a_ge_b    = ({ea, ma} >= {eb, mb});
        s_big     = a_ge_b ? sa : sb;
        e_big     = a_ge_b ? ea : eb;
        e_small   = a_ge_b ? eb : ea;
        sig_big   = a_ge_b ? siga : sigb;
        sig_small = a_ge_b ? sigb : siga;

        shamt = 32'(e_big) - 32'(e_small);
        wide  = {sig_small, 3'b000, {ExtW{1'b0}}} >> shamt;
        // Everything shifted below the sticky position is folded into sticky.
        if (shamt > MANT_W + 2) begin
            aligned = {{(ExtW-1){1'b0}}, |sig_small};
        end else begin
            aligned = {wide[2*ExtW-1:ExtW+1], |wide[ExtW:0]};
        end
    end

    logic [ExtW:0] sum;

    always_comb begin
        if (sub_q) begin
            sum = {1'b0, big_q} - {1'b0, small_q};
        end else begin
            sum = {1'b0, big_q} + {1'b0, small_q};
        end
    end

    // Rounding and final packing, registered on the edge into DONE.
    logic              inexact, rnd_up;
    logic [SigW:0]     sig_r;
    logic [EXP_W:0]    exp_r;
    logic [MANT_W-1:0] mant_r;
    logic [W-1:0]      rnd_data;
    logic [3:0]        rnd_status;

    always_comb begin
        inexact = |man_q[2:0];
`ifdef FPU_ROUND_NEAREST_EN
        rnd_up = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
`else
        rnd_up = 1'b0;
`endif
        sig_r  = {1'b0, man_q[ExtW-1:3]} + {{SigW{1'b0}}, rnd_up};
        exp_r  = exp_q;
        mant_r = sig_r[MANT_W-1:0];
        if (sig_r[SigW]) begin
            exp_r  = exp_q + ExpInc;
            mant_r = sig_r[MANT_W:1];
        end

        rnd_data   = {sign_q, exp_r[EXP_W-1:0], mant_r};
        rnd_status = {3'b000, inexact};
        if (ovf_q) begin
            rnd_data   = {sign_q, ExpOnes, {MANT_W{1'b0}}};
            rnd_status = 4'b0101;
        end else if (zero_q) begin
            rnd_data   = '0;
            rnd_status = 4'b1000;
        end else if (uf_q) begin
            rnd_data   = {sign_q, {(W-1){1'b0}}};
            rnd_status = 4'b1011;
        end else if (exp_r >= {1'b0, ExpOnes}) begin
            rnd_data   = {sign_q, ExpOnes, {MANT_W{1'b0}}};
            rnd_status = 4'b0101;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        big_d    = big_q;
        small_d  = small_q;
        man_d    = man_q;
        sub_d    = sub_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        uf_d     = uf_q;
        data_d   = data_q;
        status_d = status_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_in) begin
                    a_d     = op_A_in;
                    b_d     = op_B_in;
                    op_d    = op_in;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                sign_d  = s_big;
                exp_d   = {1'b0, e_big};
                big_d   = {sig_big, 3'b000};
                small_d = aligned;
                sub_d   = sa ^ sb;
                ovf_d   = (&ea) | (&eb);
                zero_d  = 1'b0;
                uf_d    = 1'b0;
                state_d = StAdd;
            end
            StAdd: begin
                if (sum[ExtW]) begin
                    man_d = {sum[ExtW:2], sum[1] | sum[0]};
                    exp_d = exp_q + ExpInc;
                end else begin
                    man_d = sum[ExtW-1:0];
                end
                state_d = StNorm;
            end
            StNorm: begin
                if (ovf_q || man_q[ExtW-1]) begin
                    state_d = StRound;
                end else if (man_q == '0) begin
                    // Exact cancellation is always +0.
                    zero_d  = 1'b1;
                    sign_d  = 1'b0;
                    state_d = StRound;
                end else if (exp_q <= ExpInc) begin
                    uf_d    = 1'b1;
                    state_d = StRound;
                end else begin
                    man_d = {man_q[ExtW-2:0], 1'b0};
                    exp_d = exp_q - ExpInc;
                end
            end
            StRound: begin
                data_d   = rnd_data;
                status_d = rnd_status;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            big_q    <= '0;
            small_q  <= '0;
            man_q    <= '0;
            sub_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            uf_q     <= 1'b0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            big_q    <= big_d;
            small_q  <= small_d;
            man_q    <= man_d;
            sub_q    <= sub_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            uf_q     <= uf_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        busy_out   = (state_q == StAlign) || (state_q == StAdd) ||
                     (state_q == StNorm) || (state_q == StRound);
        done_out   = (state_q == StDone);
        data_out   = data_q;
        status_out = status_q;
    end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Self-checking bench for fpu_addsub_param: vector table plus handshake/reset sequences,
// with a done-driven scoreboard comparing data, status and latency.
module tb_fpu_addsub_param;
    localparam int unsigned EXP_W  = 6;
    localparam int unsigned MANT_W = 25;
    localparam int unsigned W      = 1 + EXP_W + MANT_W;

    localparam logic [MANT_W-1:0] M0    = '0;
    localparam logic [MANT_W-1:0] M1    = {{(MANT_W-1){1'b0}}, 1'b1};
    localparam logic [MANT_W-1:0] M2    = {{(MANT_W-2){1'b0}}, 2'b10};
    localparam logic [MANT_W-1:0] MHalf = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [MANT_W-1:0] MOnes = '1;

    logic         clock;
    logic         reset;
    logic         start_in;
    logic         op_in;
    logic [W-1:0] op_A_in;
    logic [W-1:0] op_B_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    fpu_addsub_param #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_in   (start_in),
        .op_in      (op_in),
        .op_A_in    (op_A_in),
        .op_B_in    (op_B_in),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .data_out   (data_out),
        .status_out (status_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic [3:0]   status;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   status;
        int           lat;
        int           e0;
        int           id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    function automatic logic [W-1:0] mk(input logic s, input int e, input logic [MANT_W-1:0] m);
        return {s, e[EXP_W-1:0], m};
    endfunction

    function automatic vec_t mkv(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] d, input logic [3:0] st, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.data = d; v.status = st; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        failures++;
        $display("FAIL %s", msg);
    endtask

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Scoreboard: pop one expectation per done pulse.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (done_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_done: done_out=1 with nothing outstanding, required 0");
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("data[%0d]", e.id), 64'(data_out), 64'(e.data));
                    check($sformatf("status[%0d]", e.id), 64'(status_out), 64'(e.status));
                    check($sformatf("latency[%0d]", e.id), 64'(cyc - e.e0), 64'(e.lat));
                    check($sformatf("busy_in_done[%0d]", e.id), 64'(busy_out), 64'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Call at #2 after an edge with the DUT in IDLE or DONE; returns #2 after the sampling edge.
    task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int id, input logic [W-1:0] d, input logic [3:0] st,
                         input int lat, input bit track);
        exp_t e;
        start_in = 1'b1;
        op_in    = op;
        op_A_in  = a;
        op_B_in  = b;
        if (track) begin
            e.data = d; e.status = st; e.lat = lat; e.e0 = cyc + 1; e.id = id;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #2;
        start_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (sb_q.size() != 0) begin
            fail_now($sformatf("timeout %s: %0d results outstanding, required 0", name,
                               sb_q.size()));
            sb_q.delete();
        end
    endtask

    logic [W-1:0] one, two, three;
    logic [3:0]   st_rn;
    bit           seen_done;
    int           n;

    initial begin : main
        one   = mk(1'b0, 31, M0);
        two   = mk(1'b0, 32, M0);
        three = mk(1'b0, 32, MHalf);

        reset    = 1'b1;
        start_in = 1'b0;
        op_in    = 1'b0;
        op_A_in  = '0;
        op_B_in  = '0;
        repeat (2) @(posedge clock);
        #2;
        check("reset_busy", 64'(busy_out), 64'(0));
        check("reset_done", 64'(done_out), 64'(0));
        check("reset_data", 64'(data_out), 64'(0));
        check("reset_status", 64'(status_out), 64'(0));
        reset = 1'b0;
        @(posedge clock);
        #2;

        vecs.push_back(mkv(1'b0, one, two, three, 4'b0000, 4));
        vecs.push_back(mkv(1'b1, one, one, '0, 4'b1000, 4));
        vecs.push_back(mkv(1'b1, mk(1'b0, 31, M1), one, mk(1'b0, 6, M0), 4'b0000, 29));
        vecs.push_back(mkv(1'b0, mk(1'b0, 62, MOnes), mk(1'b0, 62, MOnes),
                           mk(1'b0, 63, M0), 4'b0101, 4));
`ifdef FPU_ROUND_NEAREST_EN
        vecs.push_back(mkv(1'b0, one, mk(1'b0, 5, MHalf), mk(1'b0, 31, M1), 4'b0001, 4));
        vecs.push_back(mkv(1'b1, one, mk(1'b0, 1, M0), one, 4'b0001, 5));
        vecs.push_back(mkv(1'b0, mk(1'b0, 31, M1), mk(1'b0, 5, M0), mk(1'b0, 31, M2),
                           4'b0001, 4));
`else
        vecs.push_back(mkv(1'b0, one, mk(1'b0, 5, MHalf), one, 4'b0001, 4));
        vecs.push_back(mkv(1'b1, one, mk(1'b0, 1, M0), mk(1'b0, 30, MOnes), 4'b0001, 5));
        vecs.push_back(mkv(1'b0, mk(1'b0, 31, M1), mk(1'b0, 5, M0), mk(1'b0, 31, M1),
                           4'b0001, 4));
`endif
        vecs.push_back(mkv(1'b1, two, one, one, 4'b0000, 5));
        vecs.push_back(mkv(1'b0, one, one, two, 4'b0000, 4));
        vecs.push_back(mkv(1'b0, mk(1'b0, 0, M1), one, one, 4'b0000, 4));
        vecs.push_back(mkv(1'b0, mk(1'b1, 0, M0), mk(1'b1, 0, M0), '0, 4'b1000, 4));
        vecs.push_back(mkv(1'b0, mk(1'b0, 63, M0), one, mk(1'b0, 63, M0), 4'b0101, 4));
        vecs.push_back(mkv(1'b1, mk(1'b0, 3, M1), mk(1'b0, 3, M0), '0, 4'b1011, 6));
        vecs.push_back(mkv(1'b1, mk(1'b1, 3, M1), mk(1'b1, 3, M0), mk(1'b1, 0, M0),
                           4'b1011, 6));
        vecs.push_back(mkv(1'b1, one, mk(1'b1, 32, M0), three, 4'b0000, 4));
        vecs.push_back(mkv(1'b0, mk(1'b1, 31, M0), one, '0, 4'b1000, 4));
        vecs.push_back(mkv(1'b0, one, mk(1'b0, 5, M0), one, 4'b0001, 4));

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, i, vecs[i].data, vecs[i].status,
                  vecs[i].lat, 1'b1);
            check($sformatf("busy_after_start[%0d]", i), 64'(busy_out), 64'(1));
            wait_drain(60, $sformatf("vec%0d", i));
            @(posedge clock);
            #2;
            check($sformatf("idle_after[%0d]", i), 64'(busy_out), 64'(0));
        end

        // Back-to-back: new start accepted in the DONE cycle.
        issue(1'b0, one, two, 100, three, 4'b0000, 4, 1'b1);
        n = 0;
        while (done_out !== 1'b1 && n < 20) begin
            @(posedge clock);
            #2;
            n++;
        end
        check("b2b_done_seen", 64'(done_out), 64'(1));
        check("b2b_busy_in_done", 64'(busy_out), 64'(0));
        issue(1'b1, one, one, 101, '0, 4'b1000, 4, 1'b1);
        wait_drain(40, "b2b");

        // start_in while busy must be ignored.
        issue(1'b1, mk(1'b0, 31, M1), one, 102, mk(1'b0, 6, M0), 4'b0000, 29, 1'b1);
        repeat (3) begin
            @(posedge clock);
            #2;
        end
        start_in = 1'b1;
        op_in    = 1'b0;
        op_A_in  = one;
        op_B_in  = two;
        @(posedge clock);
        #2;
        start_in = 1'b0;
        wait_drain(60, "ignore_start");
        repeat (8) begin
            @(posedge clock);
            #2;
        end

        // Reset during NORM kills the operation.
        issue(1'b1, mk(1'b0, 31, M1), one, 0, '0, 4'b0000, 0, 1'b0);
        repeat (4) begin
            @(posedge clock);
            #2;
        end
        check("norm_busy", 64'(busy_out), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        check("rst_norm_busy", 64'(busy_out), 64'(0));
        check("rst_norm_done", 64'(done_out), 64'(0));
        check("rst_norm_data", 64'(data_out), 64'(0));
        check("rst_norm_status", 64'(status_out), 64'(0));
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #2;
            if (done_out === 1'b1) seen_done = 1'b1;
        end
        check("no_done_after_reset", 64'(seen_done), 64'(0));
        issue(1'b0, one, two, 103, three, 4'b0000, 4, 1'b1);
        wait_drain(40, "after_reset");
        @(posedge clock);
        #2;

        // Reset wins over a simultaneous start.
        reset    = 1'b1;
        start_in = 1'b1;
        op_in    = 1'b0;
        op_A_in  = one;
        op_B_in  = two;
        @(posedge clock);
        #2;
        reset    = 1'b0;
        start_in = 1'b0;
        check("rst_start_busy", 64'(busy_out), 64'(0));
        check("rst_start_data", 64'(data_out), 64'(0));
        @(posedge clock);
        #2;
        check("rst_start_idle", 64'(busy_out), 64'(0));
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #2;
            if (done_out === 1'b1) seen_done = 1'b1;
        end
        check("rst_start_no_done", 64'(seen_done), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
